// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: architectural width, canonical NOP and
// the (pc, instruction) packet carried from fetch into the IF/ID register.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch packets that absorbs responses while the
// IF/ID register is stalled or still draining older entries.
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_pkt_t    i_data,
   output fetch_pkt_t    o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   fetch_pkt_t    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC and credit tracking, squash of stale responses
// after a redirect, and the IF/ID register that feeds the decoder.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_resp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_instr;
   logic [XLEN-1:0] r_if_pc;

   logic [CW-1:0]   w_buf_count;
   logic            w_buf_full;
   logic            w_buf_empty;
   fetch_pkt_t      w_buf_head;
   fetch_pkt_t      w_resp_pkt;
   logic [CW:0]     w_credit_sum;
   logic            w_accept;
   logic            w_resp_drop;
   logic            w_resp_take;
   logic            w_bypass;
   logic            w_push;
   logic            w_pop;

   // Credits count both in-flight requests (including ones to be dropped) and
   // buffered responses, so a push can never find the buffer full.
   assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, w_buf_count};
   assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < DEPTH_L);
   assign imem_req_addr  = r_pc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
   assign w_resp_take = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_bypass    = w_resp_take && w_buf_empty && !stall;
   assign w_push      = w_resp_take && !w_bypass;
   assign w_pop       = !redirect_valid && !stall && !w_buf_empty;
   assign w_resp_pkt  = '{pc: r_resp_pc, instr: imem_resp_data};

   fetch_buffer #(.DEPTH(DEPTH)) u_fetch_buffer (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_resp_pkt),
      .o_head  (w_buf_head),
      .o_count (w_buf_count),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_if_valid    <= 1'b0;
         r_if_instr    <= NOP_INSTR;
         r_if_pc       <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
         if (redirect_valid) begin
            // Every request still in flight is stale; a response landing in
            // this very cycle is already gone, so it is not counted again.
            r_pc       <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_drop_cnt <= r_outstanding - CW'(imem_resp_valid);
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
         end else begin
            if (w_accept)    r_pc       <= r_pc + 32'd4;
            if (w_resp_take) r_resp_pc  <= r_resp_pc + 32'd4;
            if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
            if (!stall) begin
               if (!w_buf_empty) begin
                  r_if_valid <= 1'b1;
                  r_if_instr <= w_buf_head.instr;
                  r_if_pc    <= w_buf_head.pc;
               end else if (w_bypass) begin
                  r_if_valid <= 1'b1;
                  r_if_instr <= imem_resp_data;
                  r_if_pc    <= r_resp_pc;
               end else begin
                  r_if_valid <= 1'b0;
                  r_if_instr <= NOP_INSTR;
               end
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(w_push && w_buf_full && !w_pop));

   assign if_valid       = r_if_valid;
   assign if_instruction = r_if_instr;
   assign if_pc          = r_if_pc;

endmodule
